// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated multiplexer.
package arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Source index width; a single channel still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_grant.sv
// Combinational grant picker: fixed priority or round-robin from a pointer,
// with an optional lock that restricts eligibility to a single channel.
module rr_grant
  import arb_mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              mode,
  input  logic              lock_en,
  input  logic [SEL_W-1:0]  lock_idx,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic [NUM_IN-1:0] elig;

  // Mask requests down to the locked channel while a packet is in flight.
  always_comb begin
    elig = req;
    if (lock_en) begin
      elig = '0;
      elig[lock_idx] = req[lock_idx];
    end
  end

  // Scan from the start point upward, wrapping at NUM_IN (not a power of 2).
  always_comb begin : scan_p
    int base;
    int c;
    base  = (mode == 1'(ARB_RR)) ? int'(ptr) : 0;
    c     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      c = base + k;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (!any && elig[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-input handshaked mux: arbitrates valid/ready sources into one registered
// output beat per cycle, with optional packet locking on in_last.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 4,
  parameter int ARB_MODE = 1,
  parameter int LOCK     = 0,
  parameter int SEL_W    = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic              locked;
  logic [SEL_W-1:0]  lock_idx;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  g;
  logic              any;
  logic              load_en;
  logic              accept;
  logic              g_last;
  logic [SEL_W-1:0]  ptr_nxt;

  rr_grant #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_grant (
    .req      (in_valid),
    .ptr      (ptr),
    .mode     (ARB_MODE == ARB_RR),
    .lock_en  (locked),
    .lock_idx (lock_idx),
    .grant    (grant),
    .idx      (g),
    .any      (any)
  );

  // The register can take a beat when empty or when it is draining this cycle.
  always_comb begin
    load_en  = !out_valid || out_ready;
    accept   = rst_n && load_en && any;
    in_ready = accept ? grant : '0;
    g_last   = in_last[g];
    ptr_nxt  = (int'(g) == NUM_IN - 1) ? '0 : g + 1'b1;
  end

  // Output stage: load on accept, otherwise empty out once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
      out_last  <= g_last;
      out_src   <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner, but only at packet end when locking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (ARB_MODE == ARB_RR && accept && (LOCK == 0 || g_last)) begin
      ptr <= ptr_nxt;
    end
  end

  // Lock tracks an open packet from its first non-last beat to its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (LOCK != 0 && accept) begin
      locked <= !g_last;
      if (!g_last) lock_idx <= g;
    end
  end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-input, handshaked multiplexer.
- Arbitrates among NUM_IN valid/ready source channels and forwards one beat per cycle into a registered output stage.
- Supports fixed-priority or round-robin selection, plus optional packet locking on a `last` flag.
- Sits between pipeline producers (e.g. multiple request sources to memory or the writeback bus) and a single consumer. It replaces hand-instantiated select muxes wherever the select must be generated by arbitration.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM_IN, 4, number of input channels (1..16; need not be a power of 2).
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- LOCK, 0, 1 = hold the grant on one channel from its first beat until its accepted beat with in_last=1.
- SEL_W, derived = max(1, clog2(NUM_IN)), width of the source index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  NUM_IN  per-channel beat available.
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  NUM_IN  per-channel end-of-packet marker.
- in_ready  out  NUM_IN  per-channel beat accepted this cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered data.
- out_last  out  1  registered last flag.
- out_src  out  SEL_W  index of the channel that supplied the beat.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, out_src=0, rr pointer=0, locked=0, lock index=0. in_ready is forced to 0 while rst_n=0.
- load_en = !out_valid || out_ready. This gives full throughput: 1 beat per cycle when out_ready is held high.
- Grant (combinational):
  - ARB_MODE=0: lowest-index channel with in_valid=1.
  - ARB_MODE=1: first channel with in_valid=1, searching from pointer upward and wrapping NUM_IN-1 -> 0.
  - locked=1: only the lock index is eligible; all other channels are masked even when the locked channel has in_valid=0.
- in_ready[g] = load_en && any eligible valid, asserted for the granted g only. At most one in_ready bit is high per cycle. in_ready depends combinationally on in_valid and out_ready.
- Accept (in_valid[g] && in_ready[g]) at edge N:
  - out_data, out_last and out_src are loaded with channel g's data, last and index g.
  - out_valid=1 from cycle N+1; latency is 1 cycle.
- Pointer update (ARB_MODE=1) on accept:
  - If LOCK=0, or the accepted beat has in_last=1: pointer = (g+1) mod NUM_IN. This wraps from NUM_IN-1 to 0 for non-power-of-2 NUM_IN.
  - Otherwise the pointer is held.
- Lock (LOCK=1):
  - An accepted beat with in_last=0 sets locked=1 and lock index=g.
  - An accepted beat with in_last=1 clears locked.
  - A single-beat packet never sets locked.
- When LOCK=0, in_last is passed through only and has no effect on arbitration.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_last and out_src stay stable and no in_ready is asserted.
- Output drain: out_valid=1, out_ready=1 and no eligible valid -> out_valid=0 next cycle; out_data holds its last value.
- Simultaneous out_ready=1 and a new accept in the same cycle: the register is reloaded, out_valid stays 1, and no bubble occurs.
- NUM_IN=1: the grant is always channel 0; out_src is tied to 0.
- Reset mid-packet: clears locked and the pointer; arbitration restarts from channel 0.

Decomposition:
- Shared package holds:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - A clog2 function used to derive SEL_W.
- Sub-module rr_grant: purely combinational. Inputs are the request vector, pointer, mode, lock mask and lock index; outputs are the one-hot grant and the encoded index.
- The arb_mux top holds the output register, pointer and lock state.

Test Plan:
- Reset check: assert rst_n=0 mid-stream -> outputs immediately 0; out_valid=0, in_ready=0; after release, first grant goes to channel 0.
- Round-robin fairness: NUM_IN=4, ARB_MODE=1, all in_valid=1, out_ready=1, data=i*0x11 -> out_src sequence 0,1,2,3,0,1; out_data 0x00,0x11,0x22,0x33 repeating; one beat per cycle.
- Fixed priority: ARB_MODE=0, in_valid=4'b1010 held -> out_src stays 1 and channel 3 is never granted; drop in_valid[1] -> out_src=3 on the next accept.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_src stable, in_ready all 0; raise out_ready -> drained and reloaded in the same cycle with no bubble.
- Lock: LOCK=1; channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout -> three consecutive out_src=2, then out_src=0. Channel 2 deasserting valid mid-packet -> no grant to channel 0 until channel 2's last beat is accepted.
- Wrap, non-power-of-2: NUM_IN=3, only channel 2 valid, then all valid -> after channel 2 is accepted, pointer=0 and the next out_src is 0.
